regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Architectural register file and pending-write scoreboard in the dispatcher. Consumes the registered
//  write-back payload (wb_dispatcher_inf_t) from the writeback stage and serves operand reads to issue.
//  Per-register pending counters track in-flight writes, so RAW/WAW hazards stall issue until writeback.
// PARAMETERS
//  NUM_REGS   32  architectural registers; x0 hardwired zero
//  REG_WIDTH  5   register index width, $clog2(NUM_REGS)
//  PEND_BITS  2   pending-counter width per register; max in-flight writes per rd = 2**PEND_BITS-1
// PORTS
//  clk                clk  in   1          clock
//  rst                rst  in   1          synchronous, active-high reset
//  wb_dispatcher_inf  in   struct     {wr_en, rd[REG_WIDTH], wr_data[32]} from writeback stage
//  issue_valid        in   1          instruction presented for issue this cycle
//  issue_rs1          in   REG_WIDTH  source 1 index
//  issue_rs2          in   REG_WIDTH  source 2 index
//  issue_uses_rs1     in   1          instruction reads rs1
//  issue_uses_rs2     in   1          instruction reads rs2
//  issue_rd           in   REG_WIDTH  destination index
//  issue_rd_write     in   1          instruction will write rd
//  issue_stall        out  1          hazard: instruction not accepted this cycle
//  rs1_data           out  32         operand 1 (comb. read)
//  rs2_data           out  32         operand 2 (comb. read)
//  sb_error           out  1          sticky: writeback arrived for rd with pending count 0
// BEHAVIOUR
//  - Reset: all regs 0, all pending counters 0, sb_error 0. Outputs are combinational from cleared state.
//  - accept = issue_valid & ~issue_stall. inc = accept & issue_rd_write & (issue_rd!=0);
//    dec = wb.wr_en & (wb.rd!=0).
//  - Pending counter cnt[r] updates at posedge: +1 on inc for r, -1 on dec for r, unchanged if both hit same r.
//  - Register write at posedge when dec: reg[wb.rd] <= wb.wr_data. wr_en with rd=0 is ignored, x0 stays 0.
//  - dec with cnt[wb.rd]==0 and no same-cycle inc to that rd: data still written, counter held at 0,
//    sb_error <= 1 (sticky until rst).
//  - Reads: rsN_data = 0 if rsN==0, else reg[rsN]. Read of a reg written this cycle returns OLD value
//    (see macro).
//  - issue_stall = issue_valid & (rawN for N in 1,2 | waw). rawN = usesN & rsN!=0 & cnt[rsN]!=0 & ~bypN.
//    waw = issue_rd_write & issue_rd!=0 & cnt[issue_rd]==MAX.
//  - issue_stall is 0 whenever issue_valid=0. No state changes on a stalled issue.
//  - Reset asserted mid-operation discards all pending counts; writebacks arriving after reset
//    (in-flight) will set sb_error.
//  - Counter saturation: inc never occurs at MAX (waw stall guarantees it); no wrap.
// CONFIGURATION
//  WB_BYPASS_EN defined: bypN = wb.wr_en & wb.rd==rsN & rsN!=0 & cnt[rsN]==1. rsN_data = wb.wr_data
//    when bypN, giving zero-bubble RAW resolution.
//  Undefined: bypN = 0. Reader stalls in the writeback cycle and issues the following cycle from the
//    register array (one extra bubble).
// TESTING
//  1 Reset, read rs1=5 rs2=0 -> rs1_data=0, rs2_data=0, issue_stall=0, sb_error=0.
//  2 Issue rd=3. Next cycle issue rs1=3 -> stall=1. wb{1,3,32'hDEAD_BEEF} -> bypass: stall=0,
//    rs1_data=DEADBEEF same cycle. No bypass: stall that cycle, stall=0 next with rs1_data=DEADBEEF.
//  3 Issue rd=7 three times (cnt=3), fourth issue rd=7 -> stall=1. One wb to 7 -> fourth accepted
//    next cycle, cnt=3.
//  4 Same cycle: accepted issue rd=9 (cnt[9]=1) and wb rd=9 -> cnt[9] stays 1, reg[9] updated,
//    sb_error=0.
//  5 wb{1,0,32'h1234} then read rs1=0 -> 0, no stall. wb{1,4,..} with cnt[4]=0 -> sb_error=1, held.
//  6 cnt[2]=1, assert rst one cycle mid-flight -> cnt[2]=0, reg[2]=0. Issue rs1=2 -> stall=0.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - writeback payload and issue/operand bus for the register file scoreboard
//
// Purpose: bundles the writeback payload from the writeback stage, the issue request from the
//          dispatcher and the operand/hazard responses returned to issue.
// Signals (named from the scoreboard's point of view):
//   i_wb                 writeback payload {wr_en, rd, wr_data}
//   i_issue_valid        instruction presented for issue
//   i_issue_rs1/rs2      source register indices
//   i_issue_uses_rs1/2   instruction reads the corresponding source
//   i_issue_rd           destination register index
//   i_issue_rd_write     instruction will write rd
//   o_issue_stall        hazard, instruction not accepted this cycle
//   o_rs1_data/rs2_data  combinational operand reads
//   o_sb_error           sticky writeback-without-pending-write error
// Modports: master drives the requests (dispatcher/writeback side), slave is the scoreboard.
interface regfile_scoreboard_if #(
    parameter int REG_WIDTH = 5
);
    typedef struct packed {
        logic                 wr_en;
        logic [REG_WIDTH-1:0] rd;
        logic [31:0]          wr_data;
    } wb_dispatcher_inf_t;

    wb_dispatcher_inf_t   i_wb;
    logic                 i_issue_valid;
    logic [REG_WIDTH-1:0] i_issue_rs1;
    logic [REG_WIDTH-1:0] i_issue_rs2;
    logic                 i_issue_uses_rs1;
    logic                 i_issue_uses_rs2;
    logic [REG_WIDTH-1:0] i_issue_rd;
    logic                 i_issue_rd_write;
    logic                 o_issue_stall;
    logic [31:0]          o_rs1_data;
    logic [31:0]          o_rs2_data;
    logic                 o_sb_error;

    modport master (
        output i_wb, i_issue_valid, i_issue_rs1, i_issue_rs2, i_issue_uses_rs1,
               i_issue_uses_rs2, i_issue_rd, i_issue_rd_write,
        input  o_issue_stall, o_rs1_data, o_rs2_data, o_sb_error
    );

    modport slave (
        input  i_wb, i_issue_valid, i_issue_rs1, i_issue_rs2, i_issue_uses_rs1,
               i_issue_uses_rs2, i_issue_rd, i_issue_rd_write,
        output o_issue_stall, o_rs1_data, o_rs2_data, o_sb_error
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - architectural register file with per-register pending-write scoreboard
//
// Purpose: holds the architectural registers (x0 hardwired to zero), serves combinational operand
//          reads to issue and tracks in-flight writes per destination register so that RAW and
//          WAW hazards stall issue until writeback.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset (clears registers, pending counters and error)
//   sb_if   regfile_scoreboard_if.slave: writeback payload, issue request, operands, stall, error
// Configuration macro: WB_BYPASS_EN - when defined, a writeback retiring the last pending write to
//          a source register forwards its data to the reader in the same cycle (no RAW bubble).
module regfile_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_WIDTH = 5,
    parameter int PEND_BITS = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    regfile_scoreboard_if.slave sb_if
);
    localparam logic [PEND_BITS-1:0] CNT_MAX = '1;
    localparam logic [PEND_BITS-1:0] CNT_ONE = PEND_BITS'(1);

    logic [31:0]          r_regs [NUM_REGS];
    logic [PEND_BITS-1:0] r_cnt  [NUM_REGS];
    logic                 r_sb_error;

    logic [REG_WIDTH-1:0] w_rs1;
    logic [REG_WIDTH-1:0] w_rs2;
    logic [REG_WIDTH-1:0] w_rd;
    logic [REG_WIDTH-1:0] w_wb_rd;
    logic                 w_byp1;
    logic                 w_byp2;
    logic                 w_raw1;
    logic                 w_raw2;
    logic                 w_waw;
    logic                 w_stall;
    logic                 w_inc;
    logic                 w_dec;
    logic                 w_underflow;

    always_comb begin
        w_rs1   = sb_if.i_issue_rs1;
        w_rs2   = sb_if.i_issue_rs2;
        w_rd    = sb_if.i_issue_rd;
        w_wb_rd = sb_if.i_wb.rd;

`ifdef WB_BYPASS_EN
        // Forward only when this writeback retires the last outstanding write to the source;
        // with more writes pending the forwarded value would be stale.
        w_byp1 = sb_if.i_wb.wr_en && (w_wb_rd == w_rs1) && (w_rs1 != '0) && (r_cnt[w_rs1] == CNT_ONE);
        w_byp2 = sb_if.i_wb.wr_en && (w_wb_rd == w_rs2) && (w_rs2 != '0) && (r_cnt[w_rs2] == CNT_ONE);
`else
        w_byp1 = 1'b0;
        w_byp2 = 1'b0;
`endif

        w_raw1  = sb_if.i_issue_uses_rs1 && (w_rs1 != '0) && (r_cnt[w_rs1] != '0) && !w_byp1;
        w_raw2  = sb_if.i_issue_uses_rs2 && (w_rs2 != '0) && (r_cnt[w_rs2] != '0) && !w_byp2;
        // A saturated counter must not be incremented, so a full rd blocks issue.
        w_waw   = sb_if.i_issue_rd_write && (w_rd != '0) && (r_cnt[w_rd] == CNT_MAX);
        w_stall = sb_if.i_issue_valid && (w_raw1 || w_raw2 || w_waw);

        w_inc   = sb_if.i_issue_valid && !w_stall && sb_if.i_issue_rd_write && (w_rd != '0);
        w_dec   = sb_if.i_wb.wr_en && (w_wb_rd != '0);
        // A same-cycle issue to the same rd covers the writeback, so that case is not an error.
        w_underflow = w_dec && (r_cnt[w_wb_rd] == '0) && !(w_inc && (w_rd == w_wb_rd));

        sb_if.o_issue_stall = w_stall;
        sb_if.o_rs1_data    = (w_rs1 == '0) ? 32'd0 : (w_byp1 ? sb_if.i_wb.wr_data : r_regs[w_rs1]);
        sb_if.o_rs2_data    = (w_rs2 == '0) ? 32'd0 : (w_byp2 ? sb_if.i_wb.wr_data : r_regs[w_rs2]);
        sb_if.o_sb_error    = r_sb_error;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= '0;
            end
            r_sb_error <= 1'b0;
        end else begin
            // x0 never gets an increment, so its counter stays at its reset value.
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_inc && (w_rd == REG_WIDTH'(r)) && !(w_dec && (w_wb_rd == REG_WIDTH'(r)))) begin
                    r_cnt[r] <= r_cnt[r] + CNT_ONE;
                end else if (w_dec && (w_wb_rd == REG_WIDTH'(r)) && !(w_inc && (w_rd == REG_WIDTH'(r)))
                             && (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - CNT_ONE;
                end
            end
            if (w_dec) begin
                r_regs[w_wb_rd] <= sb_if.i_wb.wr_data;
            end
            if (w_underflow) begin
                r_sb_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard (directed + randomized)
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.REG_WIDTH(5)) sb_if ();

    regfile_scoreboard #(
        .NUM_REGS (32),
        .REG_WIDTH(5),
        .PEND_BITS(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .sb_if(sb_if)
    );

    // Reference model: architectural values, number of in-flight writes per register, error flag.
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_err;

    function automatic bit m_byp(input int rs);
`ifdef WB_BYPASS_EN
        return sb_if.i_wb.wr_en && (int'(sb_if.i_wb.rd) == rs) && (rs != 0) && (m_cnt[rs] == 1);
`else
        return (rs < 0);
`endif
    endfunction

    function automatic bit m_stall();
        int rs1 = int'(sb_if.i_issue_rs1);
        int rs2 = int'(sb_if.i_issue_rs2);
        int rd  = int'(sb_if.i_issue_rd);
        bit hz1 = sb_if.i_issue_uses_rs1 && rs1 != 0 && m_cnt[rs1] > 0 && !m_byp(rs1);
        bit hz2 = sb_if.i_issue_uses_rs2 && rs2 != 0 && m_cnt[rs2] > 0 && !m_byp(rs2);
        bit full = sb_if.i_issue_rd_write && rd != 0 && m_cnt[rd] == 3;
        return sb_if.i_issue_valid && (hz1 || hz2 || full);
    endfunction

    function automatic logic [31:0] m_read(input int rs);
        if (rs == 0) return 32'd0;
        if (m_byp(rs)) return sb_if.i_wb.wr_data;
        return m_regs[rs];
    endfunction

    // Advance the model by one clock using the inputs presented at this edge.
    task automatic model_clock();
        int rd, wrd;
        bit inc, dec;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'd0;
                m_cnt[r]  = 0;
            end
            m_err = 1'b0;
            return;
        end
        rd  = int'(sb_if.i_issue_rd);
        wrd = int'(sb_if.i_wb.rd);
        inc = sb_if.i_issue_valid && !m_stall() && sb_if.i_issue_rd_write && rd != 0;
        dec = sb_if.i_wb.wr_en && wrd != 0;
        if (dec) begin
            if (m_cnt[wrd] == 0 && !(inc && rd == wrd)) m_err = 1'b1;
            m_regs[wrd] = sb_if.i_wb.wr_data;
        end
        if (inc) m_cnt[rd] = m_cnt[rd] + 1;
        if (dec && m_cnt[wrd] > 0) m_cnt[wrd] = m_cnt[wrd] - 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_idle();
        sb_if.i_wb             = '0;
        sb_if.i_issue_valid    = 1'b0;
        sb_if.i_issue_rs1      = '0;
        sb_if.i_issue_rs2      = '0;
        sb_if.i_issue_uses_rs1 = 1'b0;
        sb_if.i_issue_uses_rs2 = 1'b0;
        sb_if.i_issue_rd       = '0;
        sb_if.i_issue_rd_write = 1'b0;
    endtask

    task automatic set_issue(input int rs1, input bit u1, input int rs2, input bit u2, input int rd, input bit w);
        sb_if.i_issue_valid    = 1'b1;
        sb_if.i_issue_rs1      = 5'(rs1);
        sb_if.i_issue_uses_rs1 = u1;
        sb_if.i_issue_rs2      = 5'(rs2);
        sb_if.i_issue_uses_rs2 = u2;
        sb_if.i_issue_rd       = 5'(rd);
        sb_if.i_issue_rd_write = w;
    endtask

    task automatic set_wb(input int rd, input logic [31:0] data);
        sb_if.i_wb.wr_en   = 1'b1;
        sb_if.i_wb.rd      = 5'(rd);
        sb_if.i_wb.wr_data = data;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        sb_if.i_issue_rs1 = 5'd5;
        sb_if.i_issue_rs2 = 5'd0;
        #2;
        checks++; if (sb_if.o_rs1_data !== 32'd0) begin failures++; $display("FAIL reset_rs1: got %h expected 0", sb_if.o_rs1_data); end
        checks++; if (sb_if.o_rs2_data !== 32'd0) begin failures++; $display("FAIL reset_rs2: got %h expected 0", sb_if.o_rs2_data); end
        checks++; if (sb_if.o_issue_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", sb_if.o_issue_stall); end
        checks++; if (sb_if.o_sb_error !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", sb_if.o_sb_error); end
        tick();
    endtask

    task automatic test_raw();
        do_reset();
        set_issue(0, 0, 0, 0, 3, 1);
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b0) begin failures++; $display("FAIL raw_producer: got %b expected 0", sb_if.o_issue_stall); end
        tick();
        set_idle();
        set_issue(3, 1, 0, 0, 0, 0);
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b1) begin failures++; $display("FAIL raw_stall: got %b expected 1", sb_if.o_issue_stall); end
        tick();
        set_wb(3, 32'hDEAD_BEEF);
        #2;
`ifdef WB_BYPASS_EN
        checks++; if (sb_if.o_issue_stall !== 1'b0) begin failures++; $display("FAIL raw_wb_stall: got %b expected 0", sb_if.o_issue_stall); end
        checks++; if (sb_if.o_rs1_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL raw_bypass: got %h expected deadbeef", sb_if.o_rs1_data); end
`else
        checks++; if (sb_if.o_issue_stall !== 1'b1) begin failures++; $display("FAIL raw_wb_stall: got %b expected 1", sb_if.o_issue_stall); end
        checks++; if (sb_if.o_rs1_data !== 32'd0) begin failures++; $display("FAIL raw_old_value: got %h expected 0", sb_if.o_rs1_data); end
`endif
        tick();
        sb_if.i_wb = '0;
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b0) begin failures++; $display("FAIL raw_after_stall: got %b expected 0", sb_if.o_issue_stall); end
        checks++; if (sb_if.o_rs1_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL raw_after_data: got %h expected deadbeef", sb_if.o_rs1_data); end
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        set_issue(0, 0, 0, 0, 7, 1);
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++; if (sb_if.o_issue_stall !== 1'b0) begin failures++; $display("FAIL waw_fill%0d: got %b expected 0", k, sb_if.o_issue_stall); end
            tick();
        end
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b1) begin failures++; $display("FAIL waw_full: got %b expected 1", sb_if.o_issue_stall); end
        tick();
        set_wb(7, 32'h0000_0777);
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b1) begin failures++; $display("FAIL waw_wb_cycle: got %b expected 1", sb_if.o_issue_stall); end
        tick();
        sb_if.i_wb = '0;
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b0) begin failures++; $display("FAIL waw_accept: got %b expected 0", sb_if.o_issue_stall); end
        tick();
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b1) begin failures++; $display("FAIL waw_refull: got %b expected 1", sb_if.o_issue_stall); end
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_issue(0, 0, 0, 0, 9, 1);
        tick();
        set_wb(9, 32'h1111_2222);
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b0) begin failures++; $display("FAIL same_accept: got %b expected 0", sb_if.o_issue_stall); end
        tick();
        set_idle();
        sb_if.i_issue_rs1 = 5'd9;
        #2;
        checks++; if (sb_if.o_rs1_data !== 32'h1111_2222) begin failures++; $display("FAIL same_data: got %h expected 11112222", sb_if.o_rs1_data); end
        checks++; if (sb_if.o_sb_error !== 1'b0) begin failures++; $display("FAIL same_err: got %b expected 0", sb_if.o_sb_error); end
        set_issue(9, 1, 0, 0, 0, 0);
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b1) begin failures++; $display("FAIL same_cnt_held: got %b expected 1", sb_if.o_issue_stall); end
        tick();
    endtask

    task automatic test_x0_error();
        do_reset();
        set_wb(0, 32'h0000_1234);
        set_issue(0, 1, 0, 1, 0, 1);
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b0) begin failures++; $display("FAIL x0_stall: got %b expected 0", sb_if.o_issue_stall); end
        tick();
        sb_if.i_wb = '0;
        #2;
        checks++; if (sb_if.o_rs1_data !== 32'd0) begin failures++; $display("FAIL x0_read: got %h expected 0", sb_if.o_rs1_data); end
        checks++; if (sb_if.o_sb_error !== 1'b0) begin failures++; $display("FAIL x0_err: got %b expected 0", sb_if.o_sb_error); end
        set_idle();
        set_wb(4, 32'h0000_0055);
        tick();
        sb_if.i_wb = '0;
        #2;
        checks++; if (sb_if.o_sb_error !== 1'b1) begin failures++; $display("FAIL underflow_err: got %b expected 1", sb_if.o_sb_error); end
        tick(); tick(); tick();
        sb_if.i_issue_rs1 = 5'd4;
        #2;
        checks++; if (sb_if.o_sb_error !== 1'b1) begin failures++; $display("FAIL underflow_sticky: got %b expected 1", sb_if.o_sb_error); end
        checks++; if (sb_if.o_rs1_data !== 32'h0000_0055) begin failures++; $display("FAIL underflow_data: got %h expected 55", sb_if.o_rs1_data); end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_issue(0, 0, 0, 0, 2, 1);
        tick();
        set_idle();
        set_wb(2, 32'h0000_00AA);
        tick();
        set_idle();
        set_issue(0, 0, 0, 0, 2, 1);
        tick();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_issue(2, 1, 0, 0, 0, 0);
        #2;
        checks++; if (sb_if.o_issue_stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b expected 0", sb_if.o_issue_stall); end
        checks++; if (sb_if.o_rs1_data !== 32'd0) begin failures++; $display("FAIL rst_reg: got %h expected 0", sb_if.o_rs1_data); end
        tick();
        set_idle();
        set_wb(2, 32'h0000_00BB);
        tick();
        sb_if.i_wb = '0;
        #2;
        checks++; if (sb_if.o_sb_error !== 1'b1) begin failures++; $display("FAIL rst_inflight_err: got %b expected 1", sb_if.o_sb_error); end
        tick();
    endtask

    task automatic test_random();
        int pend[$];
        logic [31:0] e1, e2;
        bit es;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_issue($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                      $urandom_range(0, 7), 1'($urandom));
            sb_if.i_issue_valid = ($urandom_range(0, 3) != 0);
            pend.delete();
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
            sb_if.i_wb.wr_en   = ($urandom_range(0, 2) != 0);
            sb_if.i_wb.rd      = (pend.size() > 0 && $urandom_range(0, 7) != 0)
                                 ? 5'(pend[$urandom_range(0, pend.size() - 1)]) : 5'($urandom_range(0, 7));
            sb_if.i_wb.wr_data = $urandom;
            #2;
            es = m_stall();
            e1 = m_read(int'(sb_if.i_issue_rs1));
            e2 = m_read(int'(sb_if.i_issue_rs2));
            checks++; if (sb_if.o_issue_stall !== es) begin failures++; $display("FAIL rand_stall@%0d: got %b expected %b", i, sb_if.o_issue_stall, es); end
            checks++; if (sb_if.o_rs1_data !== e1) begin failures++; $display("FAIL rand_rs1@%0d: got %h expected %h", i, sb_if.o_rs1_data, e1); end
            checks++; if (sb_if.o_rs2_data !== e2) begin failures++; $display("FAIL rand_rs2@%0d: got %h expected %h", i, sb_if.o_rs2_data, e2); end
            checks++; if (sb_if.o_sb_error !== m_err) begin failures++; $display("FAIL rand_err@%0d: got %b expected %b", i, sb_if.o_sb_error, m_err); end
            tick();
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_raw();
        test_waw();
        test_same_cycle();
        test_x0_error();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
